// File: rtl/ad_pkg.sv
// Shared definitions for the ADC capture path: default sample width and the
// averaging FSM state type.
package ad_pkg;
  localparam int AD_DATA_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    PUSH  = 2'd2
  } avg_state_t;
endpackage

// File: rtl/ad_sync_fifo.sv
// First-word-fall-through synchronous FIFO. Same-cycle push and pop are allowed,
// including a push into a full FIFO that is being popped.
module ad_sync_fifo #(
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          ad_clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_W-1:0]             wr_data,
  output logic                          full,
  input  logic                          rd_en,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_wr;
  logic              do_rd;

  assign empty = (count == '0);
  assign full  = count[AW];
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Storage is never reset; the head is masked while empty so it reads zero.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge ad_clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge ad_clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/ad_avg_buffer.sv
// Block averager for one ADC channel: means of 2^AVG_LOG2 consecutive samples
// are queued in a FWFT FIFO and drained over a valid/ready handshake.
module ad_avg_buffer
  import ad_pkg::*;
#(
  parameter int DATA_W     = AD_DATA_W,
  parameter int AVG_LOG2   = 2,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          ad_clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          sample_valid,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_ovf
);
  localparam int ACC_W = DATA_W + AVG_LOG2;

  avg_state_t          state_p0;
  logic [ACC_W-1:0]    acc_p0;
  logic [ACC_W-1:0]    acc_sum;
  logic [AVG_LOG2-1:0] cnt_p0;
  logic [DATA_W-1:0]   mean_p1;
  logic                block_done;
  logic                block_end;
  logic                push_p1;
  logic                pop;
  logic                drop;
  logic                fifo_full;
  logic                fifo_empty;

  function automatic logic [DATA_W-1:0] block_mean(input logic [ACC_W-1:0] sum);
    return sum[ACC_W-1:AVG_LOG2];
  endfunction

  assign acc_sum    = acc_p0 + ACC_W'(sample_in);
  assign block_done = (cnt_p0 == {AVG_LOG2{1'b1}});
  assign block_end  = (state_p0 == ACCUM) && en && sample_valid && block_done;
  assign push_p1    = (state_p0 == PUSH);
  assign pop        = out_valid && out_ready;
  assign drop       = push_p1 && fifo_full && !pop;
  assign out_valid  = !fifo_empty;

  // Stage 0: accumulate samples; the block's last sample moves to PUSH.
  always_ff @(posedge ad_clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      acc_p0   <= '0;
      cnt_p0   <= '0;
    end else begin
      case (state_p0)
        IDLE: begin
          acc_p0 <= '0;
          cnt_p0 <= '0;
          if (en) state_p0 <= ACCUM;
        end
        ACCUM: begin
          if (!en) begin
            state_p0 <= IDLE;
            acc_p0   <= '0;
            cnt_p0   <= '0;
          end else if (sample_valid) begin
            if (block_done) begin
              state_p0 <= PUSH;
              acc_p0   <= '0;
              cnt_p0   <= '0;
            end else begin
              acc_p0 <= acc_sum;
              cnt_p0 <= cnt_p0 + 1'b1;
            end
          end
        end
        PUSH: begin
          state_p0 <= en ? ACCUM : IDLE;
          if (en && sample_valid) begin
            acc_p0 <= ACC_W'(sample_in);
            cnt_p0 <= AVG_LOG2'(1);
          end else begin
            acc_p0 <= '0;
            cnt_p0 <= '0;
          end
        end
        default: begin
          state_p0 <= IDLE;
          acc_p0   <= '0;
          cnt_p0   <= '0;
        end
      endcase
    end
  end

  // Stage 1: registered mean, written to the FIFO during PUSH.
  always_ff @(posedge ad_clk) begin
    if (block_end) mean_p1 <= block_mean(acc_sum);
  end

  always_ff @(posedge ad_clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

  ad_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .ad_clk  (ad_clk),
    .rst     (rst),
    .wr_en   (push_p1),
    .wr_data (mean_p1),
    .full    (fifo_full),
    .rd_en   (out_ready),
    .rd_data (out_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );
endmodule

// File: tb/tb_ad_avg_buffer.sv
// Scoreboard bench for ad_avg_buffer: expected means are queued as blocks are
// fed and compared whenever the DUT hands one over.
module tb_ad_avg_buffer;
  import ad_pkg::*;
  localparam int DATA_W     = 12;
  localparam int AVG_LOG2   = 2;
  localparam int FIFO_DEPTH = 16;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic              ad_clk = 1'b0;
  logic              rst = 1'b1;
  logic              en = 1'b0;
  logic [DATA_W-1:0] sample_in = '0;
  logic              sample_valid = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [CW-1:0]     fifo_count;
  logic              overflow;
  logic              clr_ovf = 1'b0;

  int tests_run = 0;
  int failed    = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 ad_clk = ~ad_clk;

  ad_avg_buffer #(
    .DATA_W     (DATA_W),
    .AVG_LOG2   (AVG_LOG2),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .ad_clk       (ad_clk),
    .rst          (rst),
    .en           (en),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .fifo_count   (fifo_count),
    .overflow     (overflow),
    .clr_ovf      (clr_ovf)
  );

  // Every handshake the DUT completes is checked against the scoreboard head.
  always @(negedge ad_clk) begin
    logic [DATA_W-1:0] e;
    if (!rst && out_valid && out_ready) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL sb_unexpected: out_data=%0d, required no output", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failed++;
          $display("FAIL sb_data: out_data=%0d, required %0d", out_data, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge ad_clk);
    #1;
  endtask

  // Feeds four samples back to back, then runs through the PUSH cycle.
  task automatic feed_block(input int s0, input int s1, input int s2, input int s3,
                            input bit push_exp, input bit rdy_in_push, input bit clr_in_push);
    int  s[4];
    int  sum;
    logic old_rdy;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1;
      sample_in    = DATA_W'(s[i]);
      sum += s[i];
      step();
    end
    sample_valid = 1'b0;
    if (push_exp) exp_q.push_back(DATA_W'(sum >> AVG_LOG2));
    old_rdy = out_ready;
    if (rdy_in_push) out_ready = 1'b1;
    clr_ovf = clr_in_push;
    step();
    out_ready = old_rdy;
    clr_ovf   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_out_valid: got %0b, required 0", out_valid); end
    tests_run++;
    if (fifo_count !== '0) begin failed++; $display("FAIL reset_count: got %0d, required 0", fifo_count); end
    tests_run++;
    if (overflow !== 1'b0) begin failed++; $display("FAIL reset_overflow: got %0b, required 0", overflow); end
    tests_run++;
    if (out_data !== '0) begin failed++; $display("FAIL reset_out_data: got %0d, required 0", out_data); end
  endtask

  task automatic test_basic();
    int v[4];
    v[0] = 100; v[1] = 200; v[2] = 300; v[3] = 400;
    en = 1'b1; out_ready = 1'b1;
    step();
    exp_q.push_back(DATA_W'(250));
    for (int i = 0; i < 4; i++) begin
      sample_valid = 1'b1; sample_in = DATA_W'(v[i]);
      step();
    end
    sample_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL basic_push_cycle_valid: got %0b, required 0", out_valid); end
    step();
    tests_run++;
    if (out_valid !== 1'b1) begin failed++; $display("FAIL basic_valid_rise: got %0b, required 1", out_valid); end
    tests_run++;
    if (out_data !== DATA_W'(250)) begin failed++; $display("FAIL basic_mean: got %0d, required 250", out_data); end
    step();
    tests_run++;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL basic_one_cycle: got %0b, required 0", out_valid); end
  endtask

  task automatic test_truncation();
    feed_block(1, 1, 1, 2, 1'b1, 1'b0, 1'b0);
    step();
    feed_block(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b1, 1'b0, 1'b0);
    step(); step();
    tests_run++;
    if (exp_q.size() != 0) begin failed++; $display("FAIL trunc_drained: %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_back_to_back();
    int sum;
    sum = 0;
    for (int i = 0; i < 12; i++) begin
      sample_valid = 1'b1;
      sample_in    = DATA_W'(i * 37 + 5);
      sum += i * 37 + 5;
      if (i % 4 == 3) begin
        exp_q.push_back(DATA_W'(sum >> AVG_LOG2));
        sum = 0;
      end
      step();
    end
    sample_valid = 1'b0;
    step(); step(); step();
    tests_run++;
    if (exp_q.size() != 0) begin failed++; $display("FAIL b2b_means: %0d missing, required 0", exp_q.size()); end
  endtask

  task automatic test_overflow();
    out_ready = 1'b0;
    for (int k = 0; k < 17; k++)
      feed_block(100 + k, 100 + k, 100 + k, 100 + k, k < 16, 1'b0, 1'b0);
    tests_run++;
    if (fifo_count !== CW'(16)) begin failed++; $display("FAIL ovf_count: got %0d, required 16", fifo_count); end
    tests_run++;
    if (overflow !== 1'b1) begin failed++; $display("FAIL ovf_set: got %0b, required 1", overflow); end
    feed_block(90, 90, 90, 90, 1'b0, 1'b0, 1'b1);
    tests_run++;
    if (overflow !== 1'b1) begin failed++; $display("FAIL ovf_set_wins: got %0b, required 1", overflow); end
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    tests_run++;
    if (overflow !== 1'b0) begin failed++; $display("FAIL ovf_clear: got %0b, required 0", overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    out_ready = 1'b0;
    tests_run++;
    if (exp_q.size() != 0) begin failed++; $display("FAIL ovf_drain: %0d left, required 0", exp_q.size()); end
    tests_run++;
    if (fifo_count !== '0) begin failed++; $display("FAIL ovf_drain_count: got %0d, required 0", fifo_count); end
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b0;
    for (int k = 0; k < 16; k++)
      feed_block(200 + k, 200 + k, 200 + k, 200 + k, 1'b1, 1'b0, 1'b0);
    feed_block(300, 301, 302, 303, 1'b1, 1'b1, 1'b0);
    tests_run++;
    if (fifo_count !== CW'(16)) begin failed++; $display("FAIL fullpp_count: got %0d, required 16", fifo_count); end
    tests_run++;
    if (overflow !== 1'b0) begin failed++; $display("FAIL fullpp_overflow: got %0b, required 0", overflow); end
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) step();
    out_ready = 1'b0;
    tests_run++;
    if (exp_q.size() != 0) begin failed++; $display("FAIL fullpp_drain: %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_en_drop();
    en = 1'b1; out_ready = 1'b1;
    sample_valid = 1'b1; sample_in = DATA_W'(500); step();
    sample_in = DATA_W'(600); step();
    sample_valid = 1'b0; en = 1'b0;
    step(); step(); step();
    tests_run++;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL endrop_no_output: got %0b, required 0", out_valid); end
    en = 1'b1;
    step();
    feed_block(8, 8, 8, 12, 1'b1, 1'b0, 1'b0);
    step(); step();
    tests_run++;
    if (exp_q.size() != 0) begin failed++; $display("FAIL endrop_fresh_block: %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_rst_queued();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++)
      feed_block(40 * (k + 1), 0, 0, 0, 1'b1, 1'b0, 1'b0);
    tests_run++;
    if (fifo_count !== CW'(3)) begin failed++; $display("FAIL rstq_pre_count: got %0d, required 3", fifo_count); end
    rst = 1'b1; step(); rst = 1'b0;
    exp_q.delete();
    tests_run++;
    if (fifo_count !== '0) begin failed++; $display("FAIL rstq_count: got %0d, required 0", fifo_count); end
    tests_run++;
    if (out_valid !== 1'b0) begin failed++; $display("FAIL rstq_valid: got %0b, required 0", out_valid); end
    tests_run++;
    if (overflow !== 1'b0) begin failed++; $display("FAIL rstq_overflow: got %0b, required 0", overflow); end
    tests_run++;
    if (out_data !== '0) begin failed++; $display("FAIL rstq_out_data: got %0d, required 0", out_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncation();
    test_back_to_back();
    test_overflow();
    test_full_push_pop();
    test_en_drop();
    test_rst_queued();
    step();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
